// File: rtl/lsb_mem_ctrl_pkg.sv
// Shared definitions for the LSB memory-side controller: FSM states, access
// length encodings and the length-to-byte-count helper.
package lsb_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_ST   = 2'd1,
    MC_LD   = 2'd2,
    MC_COOL = 2'd3
  } mc_state_e;

  localparam logic [5:0] LEN_B = 6'd8;
  localparam logic [5:0] LEN_H = 6'd16;
  localparam logic [5:0] LEN_W = 6'd32;

  // Any length other than 16 or 32 bits is treated as a single byte.
  function automatic logic [2:0] len_nbytes(input logic [5:0] len);
    case (len)
      LEN_H:   len_nbytes = 3'd2;
      LEN_W:   len_nbytes = 3'd4;
      default: len_nbytes = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/lsb_mem_ctrl_mem_st_fifo.sv
// Circular queue of committed stores awaiting their byte-serial RAM writes.
// Power-of-two depth; a separate count register distinguishes full from empty.
module mem_st_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = DEPTH[PTR_W:0];
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push on a full queue is kept then.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  push_while_full_a: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop))
    else $error("mem_st_fifo: store pushed while queue full, entry dropped");

endmodule

// File: rtl/lsb_mem_ctrl.sv
// Memory-side responder for the load/store buffer: queues committed stores,
// serves held-level loads, and runs byte-serial accesses on a byte-wide RAM.
module lsb_mem_ctrl
  import lsb_mem_ctrl_pkg::*;
#(
  parameter int ST_FIFO_DEPTH = 4,
  parameter int ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              req_ld,
  input  logic              req_st,
  input  logic [5:0]        req_len,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_done,
  output logic [31:0]       resp_data,
  output logic              st_full,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr
);

  // Handshake: req_st is a one-cycle push accepted whenever rdy is high; req_ld
  // is a level held until the requester has seen the one-cycle resp_done pulse.

  localparam int ENT_W = ADDR_W + 32 + 3;

  mc_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        ld_nb_q, ld_nb_d;
  logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              resp_done_q, resp_done_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;

  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [ENT_W-1:0]  fifo_din, fifo_dout;
  logic [ADDR_W-1:0] st_addr;
  logic [31:0]       st_wdata;
  logic [2:0]        st_nb;

  assign fifo_din  = {req_addr, req_wdata, len_nbytes(req_len)};
  assign fifo_push = rdy && req_st;
  assign {st_addr, st_wdata, st_nb} = fifo_dout;

  mem_st_fifo #(
    .DEPTH (ST_FIFO_DEPTH),
    .W     (ENT_W)
  ) u_st_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // RAM outputs are registered one cycle ahead: the value computed here is the
  // address/data driven during the next state's cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_nb_d     = ld_nb_q;
    ld_addr_d   = ld_addr_q;
    asm_d       = asm_q;
    resp_data_d = resp_data_q;
    resp_done_d = 1'b0;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    fifo_pop    = 1'b0;
    case (state_q)
      MC_IDLE: begin
        if (!fifo_empty) begin
          state_d    = MC_ST;
          cnt_d      = 3'd0;
          ram_a_d    = st_addr;
          ram_dout_d = st_wdata[7:0];
          ram_wr_d   = 1'b1;
        end else if (req_ld && !flush) begin
          state_d   = MC_LD;
          cnt_d     = 3'd0;
          ld_addr_d = req_addr;
          ld_nb_d   = len_nbytes(req_len);
          asm_d     = '0;
          ram_a_d   = req_addr;
          ram_wr_d  = 1'b0;
        end
      end
      MC_ST: begin
        if (cnt_q == st_nb - 3'd1) begin
          fifo_pop = rdy;
          ram_wr_d = 1'b0;
          state_d  = MC_IDLE;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          ram_a_d    = st_addr + ADDR_W'(cnt_d);
          ram_dout_d = 8'(st_wdata >> {cnt_d, 3'b000});
        end
      end
      MC_LD: begin
        if (flush) begin
          state_d = MC_IDLE;
        end else begin
          // The byte read for address k arrives during cycle k+1.
          if (cnt_q != 3'd0) begin
            asm_d = asm_q | (32'(ram_din) << {cnt_q - 3'd1, 3'b000});
          end
          if (cnt_q == ld_nb_q) begin
            resp_done_d = 1'b1;
            resp_data_d = asm_d;
            state_d     = MC_COOL;
          end else begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_d != ld_nb_q) begin
              ram_a_d = ld_addr_q + ADDR_W'(cnt_d);
            end
          end
        end
      end
      MC_COOL: begin
        // req_ld is still high this cycle for the load just answered.
        state_d = MC_IDLE;
      end
      default: state_d = MC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MC_IDLE;
      cnt_q       <= '0;
      ld_nb_q     <= '0;
      ld_addr_q   <= '0;
      asm_q       <= '0;
      resp_data_q <= '0;
      resp_done_q <= 1'b0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
    end else if (rdy) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_nb_q     <= ld_nb_d;
      ld_addr_q   <= ld_addr_d;
      asm_q       <= asm_d;
      resp_data_q <= resp_data_d;
      resp_done_q <= resp_done_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
    end
  end

  assign resp_done = resp_done_q;
  assign resp_data = resp_data_q;
  assign st_full   = fifo_full;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q && rdy;

endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// Directed bench for lsb_mem_ctrl: synchronous byte RAM model, expected-write
// scoreboard, hand-computed load results and timing checks.
module tb_lsb_mem_ctrl;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst, rdy, flush, req_ld, req_st;
  logic [5:0]  req_len;
  logic [31:0] req_addr, req_wdata;
  logic        resp_done, st_full, ram_wr;
  logic [31:0] resp_data, ram_a;
  logic [7:0]  ram_din, ram_dout;

  always #5 clk = ~clk;

  lsb_mem_ctrl #(
    .ST_FIFO_DEPTH (4),
    .ADDR_W        (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .req_ld    (req_ld),
    .req_st    (req_st),
    .req_len   (req_len),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_done (resp_done),
    .resp_data (resp_data),
    .st_full   (st_full),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .ram_a     (ram_a),
    .ram_wr    (ram_wr)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          wr_cnt   = 0;
  int          done_cnt = 0;
  logic [39:0] exp_q[$];
  logic [31:0] a_log[$];
  logic [7:0]  ram [4096];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Synchronous RAM: write on posedge, read data valid the cycle after the address.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
      ram[12'h100] <= 8'h11;
      ram[12'h101] <= 8'h22;
      ram[12'h102] <= 8'h33;
      ram[12'h103] <= 8'h44;
      ram[12'h021] <= 8'h5A;
    end else if (ram_wr) begin
      ram[ram_a[11:0]] <= ram_dout;
      wr_cnt++;
      if (exp_q.size() == 0) check("wr_unexpected", 64'(exp_q.size()), 64'd1);
      else check("wr_seq", 64'({ram_a, ram_dout}), 64'(exp_q.pop_front()));
    end
    ram_din <= ram[ram_a[11:0]];
  end

  always @(negedge clk) if (resp_done) done_cnt++;

  // ---------------- driver tasks ----------------
  task automatic push_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [5:0] len);
    int nb;
    nb = (len == 6'd16) ? 2 : (len == 6'd32) ? 4 : 1;
    req_st = 1'b1; req_addr = addr; req_wdata = wdata; req_len = len;
    for (int k = 0; k < nb; k++) exp_q.push_back({addr + 32'(k), wdata[8*k +: 8]});
    @(negedge clk);
    req_st = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [5:0] len,
                         output logic [31:0] data, output int lat, output logic [31:0] cool_a);
    bit seen;
    seen = 1'b0; data = '0; lat = -1;
    a_log.delete();
    req_ld = 1'b1; req_addr = addr; req_len = len;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      a_log.push_back(ram_a);
      if (resp_done) begin seen = 1'b1; lat = i; data = resp_data; end
    end
    check("ld_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check("done_pulse", 64'(resp_done), 64'd0);
    cool_a = ram_a;
    req_ld = 1'b0;
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || ram_wr) && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_wr();
    int i;
    i = 0;
    while (!ram_wr && i < 50) begin
      @(negedge clk);
      i++;
    end
    check("wr_start", 64'(ram_wr), 64'd1);
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] d, ca;
  int          lat, d0, w0;
  bit          seen;

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0; req_ld = 1'b0; req_st = 1'b0;
    req_len = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ram_a", 64'(ram_a), 64'd0);
    check("rst_ram_wr", 64'(ram_wr), 64'd0);
    check("rst_ram_dout", 64'(ram_dout), 64'd0);
    check("rst_resp_done", 64'(resp_done), 64'd0);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    check("rst_st_full", 64'(st_full), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // LW @0x100: address walk, latency, data, cooldown with req_ld still high
    d0 = done_cnt;
    do_load(32'h100, 6'd32, d, lat, ca);
    check("lw_data", 64'(d), 64'h44332211);
    check("lw_latency", 64'(lat), 64'd5);
    for (int i = 0; i < 4; i++) check("lw_addr", 64'(a_log[i]), 64'(32'h100 + 32'(i)));
    check("cool_no_read", 64'(ca), 64'h103);
    repeat (8) @(negedge clk);
    check("lw_single_done", 64'(done_cnt - d0), 64'd1);

    // SB @0x20: one write, neighbour untouched
    w0 = wr_cnt;
    push_store(32'h20, 32'hAABBCCDD, 6'd8);
    wait_drain();
    check("sb_wr_count", 64'(wr_cnt - w0), 64'd1);
    check("sb_byte", 64'(ram[12'h020]), 64'hDD);
    check("sb_neighbour", 64'(ram[12'h021]), 64'h5A);

    // SW @0x40 followed next cycle by LW @0x40: store drains first
    push_store(32'h40, 32'h12345678, 6'd32);
    do_load(32'h40, 6'd32, d, lat, ca);
    check("raw_data", 64'(d), 64'h12345678);
    check("raw_st_first", 64'(exp_q.size()), 64'd0);

    // LH / LB zero-extension and an illegal length treated as a byte
    do_load(32'h101, 6'd16, d, lat, ca);
    check("lh_data", 64'(d), 64'h3322);
    check("lh_latency", 64'(lat), 64'd3);
    do_load(32'h103, 6'd8, d, lat, ca);
    check("lb_data", 64'(d), 64'h44);
    do_load(32'h102, 6'd0, d, lat, ca);
    check("ld_len0_data", 64'(d), 64'h33);
    check("ld_len0_latency", 64'(lat), 64'd2);
    w0 = wr_cnt;
    push_store(32'h30, 32'h000055EE, 6'd24);
    wait_drain();
    check("st_len24_count", 64'(wr_cnt - w0), 64'd1);

    // LH in flight, flush after byte 0 issued; SH pushed in the flush cycle
    d0 = done_cnt;
    req_ld = 1'b1; req_addr = 32'h60; req_len = 6'd16;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    push_store(32'h80, 32'h0000BEEF, 6'd16);
    flush = 1'b0;
    req_ld = 1'b0;
    wait_drain();
    repeat (4) @(negedge clk);
    check("flush_no_done", 64'(done_cnt - d0), 64'd0);
    check("flush_data_kept", 64'(resp_data), 64'h33);
    check("flush_sh_lo", 64'(ram[12'h080]), 64'hEF);
    check("flush_sh_hi", 64'(ram[12'h081]), 64'hBE);

    // Four back-to-back SW: full after the 4th, clears at the first pop
    for (int i = 0; i < 4; i++)
      push_store(32'h90 + 32'(4 * i), 32'hA0B0C0D0 + 32'(i), 6'd32);
    check("full_after_4", 64'(st_full), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!st_full) seen = 1'b1;
    end
    check("full_clears", 64'(seen), 64'd1);
    check("full_clear_at_pop1", 64'(exp_q.size()), 64'd12);
    wait_drain();
    check("fifo_last_word", 64'({ram[12'h09F], ram[12'h09E], ram[12'h09D], ram[12'h09C]}), 64'hA0B0C0D3);

    // rdy low mid-store: writes suppressed, state frozen, then completes
    push_store(32'hB0, 32'hCAFEF00D, 6'd32);
    wait_wr();
    @(negedge clk);
    rdy = 1'b0;
    w0 = wr_cnt;
    #1;
    check("rdy_wr_forced", 64'(ram_wr), 64'd0);
    repeat (3) @(negedge clk);
    check("rdy_hold_a", 64'(ram_a), 64'hB1);
    check("rdy_no_write", 64'(wr_cnt - w0), 64'd0);
    rdy = 1'b1;
    wait_drain();
    check("rdy_word", 64'({ram[12'h0B3], ram[12'h0B2], ram[12'h0B1], ram[12'h0B0]}), 64'hCAFEF00D);

    // Address wrap at 2^32
    push_store(32'hFFFF_FFFF, 32'h0000_9977, 6'd16);
    wait_drain();
    check("wrap_lo", 64'(ram[12'hFFF]), 64'h77);
    check("wrap_hi", 64'(ram[12'h000]), 64'h99);

    // Async reset in the middle of a store with another queued
    push_store(32'hC0, 32'h01020304, 6'd32);
    push_store(32'hC4, 32'h05060708, 6'd32);
    wait_wr();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("arst_ram_a", 64'(ram_a), 64'd0);
    check("arst_ram_wr", 64'(ram_wr), 64'd0);
    check("arst_ram_dout", 64'(ram_dout), 64'd0);
    check("arst_resp_data", 64'(resp_data), 64'd0);
    check("arst_resp_done", 64'(resp_done), 64'd0);
    check("arst_st_full", 64'(st_full), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    w0 = wr_cnt;
    repeat (10) @(negedge clk);
    check("arst_fifo_empty", 64'(wr_cnt - w0), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
